instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch stage for the RV32I pipeline on iCE40.
- Holds the PC and drives the word address into the synchronous instruction ROM's port A. The ROM has registered read, 1-cycle latency.
- Presents each fetched instruction and its PC to decode over a valid/ready handshake.
- Accepts a PC redirect from execute for branches and jumps; a redirect kills the fetch in flight.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- DEPTH_LOG, 12: ROM address width in words. rom_addr = next_pc[DEPTH_LOG+1:2].
- WIDTH, 32: instruction width.

Ports:
- clk  in  1  rising-edge clock, shared with the ROM.
- resetb  in  1  reset, asynchronous, active-low.
- rom_addr  out  DEPTH_LOG  word address to ROM port A; combinational from next_pc.
- rom_data  in  WIDTH  ROM port A registered output; valid 1 cycle after rom_addr.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  32  redirect target.
- out_valid  out  1  out_instr/out_pc valid for decode.
- out_ready  in  1  decode accepts this cycle.
- out_instr  out  WIDTH  fetched instruction; equals rom_data.
- out_pc  out  32  PC of out_instr.
- out_misalign  out  1  present only with FETCH_MISALIGN_EN.

Behaviour:
- Clock and reset: one clock, clk. resetb is asynchronous, active-low.
- Registers: state (IDLE, RUN), f2_valid, f2_pc. f2_pc is the PC whose ROM data appears on rom_data this cycle.
- Reset (asynchronous, resetb low):
  - state=IDLE, f2_valid=0, f2_pc=RESET_PC.
  - out_valid=0 immediately. out_pc=RESET_PC.
  - rom_addr=RESET_PC[DEPTH_LOG+1:2].
- State IDLE:
  - next_pc = redirect_valid ? redirect_pc : RESET_PC.
  - Next edge: state=RUN, f2_valid=1, f2_pc=next_pc.
- State RUN, evaluated in priority order:
  1. redirect_valid=1: next_pc=redirect_pc. On the edge, f2_pc<=redirect_pc and f2_valid<=1. The current instruction is killed.
  2. Else f2_valid & ~out_ready (stall): next_pc=f2_pc. The ROM re-reads the same word, so rom_data and out_pc hold stable.
  3. Else: next_pc=f2_pc+4, wrapping mod 2^32. On the edge, f2_pc<=f2_pc+4.
- Outputs:
  - out_valid = f2_valid & ~redirect_valid & (state==RUN).
  - out_instr = rom_data. out_pc = f2_pc.
- Handshake:
  - Transfer occurs when out_valid & out_ready.
  - out_valid, once high, stays high with stable out_instr/out_pc until the transfer completes or a redirect arrives.
- Throughput and latency:
  - 1 instruction/cycle when not stalled.
  - Redirect-to-target latency is 1 cycle: the target is presented on the cycle after redirect_valid.
- Simultaneous events:
  - redirect_valid with out_ready=0: the redirect wins.
  - redirect_valid with out_ready=1: no transfer, since out_valid is forced low.
- Alignment and range:
  - redirect_pc[1:0] is ignored for addressing.
  - Word index >= 2^DEPTH_LOG aliases by truncation.
  - Index >= ROM depth returns undefined data; software must not target it.
- Reset mid-operation: all state is discarded and the stage restarts from IDLE. Any fetch in flight is dropped.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- With the macro defined:
  - Register f2_misalign <= redirect_pc[1:0]!=0 on a redirect edge; cleared on sequential advance and on reset.
  - out_misalign = f2_misalign and is qualified by out_valid.
  - On a misaligned fetch, out_pc carries the full unaligned redirect_pc, and sequential fetch proceeds from that value +4.
  - Execute traps on the flag.
- Without the macro:
  - No out_misalign port.
  - Low two bits of redirect_pc are forced to 0 before being stored into f2_pc.

Test Plan:
- Reset start: ROM[0..3]=0x11,0x22,0x33,0x44, out_ready=1, release resetb.
  - out_valid=0 for the first cycle.
  - Then (out_pc,out_instr) = (0,0x11), (4,0x22), (8,0x33), (12,0x44) on consecutive cycles.
- Stall: hold out_ready=0 for 3 cycles while out_pc=8.
  - out_pc=8 and out_instr=0x33 stable; rom_addr=2.
  - After out_ready=1: pc 12 follows on the next cycle.
- Redirect: redirect_valid=1, redirect_pc=0x40 while out_pc=8.
  - That cycle: out_valid=0.
  - Next cycle: out_pc=0x40, out_instr=ROM[16]. Then 0x44.
- Redirect during stall: out_ready=0, redirect_pc=0x80.
  - Next cycle: out_pc=0x80. The stalled pc 8 is never transferred.
- Async reset mid-run: drop resetb asynchronously at out_pc=0x44.
  - out_valid falls immediately.
  - After release, fetch restarts at RESET_PC with 1-cycle bubble.
- FETCH_MISALIGN_EN: redirect_pc=0x42.
  - Next cycle: out_misalign=1, out_pc=0x42.
  - Following fetch: out_misalign=0.
  - Without the macro, the same stimulus gives out_pc=0x40.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - RV32I instruction fetch stage driving a 1-cycle-latency synchronous ROM
//
// Optional feature macro: FETCH_MISALIGN_EN
//   defined   : low PC bits of a redirect are kept, and out_misalign flags the fetch.
//   undefined : redirect_pc[1:0] is forced to zero, and there is no out_misalign port.
//
// Ports:
//   clk            in   rising-edge clock, shared with the ROM
//   resetb         in   asynchronous active-low reset
//   rom_addr       out  ROM port A word address, combinational from next_pc
//   rom_data       in   ROM port A registered read data (for the address of the previous cycle)
//   redirect_valid in   execute requests a PC change this cycle
//   redirect_pc    in   redirect target
//   out_valid      out  out_instr/out_pc valid for decode
//   out_ready      in   decode accepts this cycle
//   out_instr      out  fetched instruction (rom_data)
//   out_pc         out  PC of out_instr
//   out_misalign   out  fetch came from a misaligned redirect (FETCH_MISALIGN_EN only)

module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH_LOG = 12,
  parameter int          WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 resetb,
  output logic [DEPTH_LOG-1:0] rom_addr,
  input  logic [WIDTH-1:0]     rom_data,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_instr,
`ifdef FETCH_MISALIGN_EN
  output logic                 out_misalign,
`endif
  output logic [31:0]          out_pc
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic        f2_valid, f2_valid_nxt;
  logic [31:0] f2_pc;
  logic [31:0] next_pc;
  logic [31:0] redirect_tgt;

`ifdef FETCH_MISALIGN_EN
  logic f2_misalign, f2_misalign_nxt;
  // Keep the full target so execute can see the faulting address.
  assign redirect_tgt = redirect_pc;
`else
  // Word-align the target; the stored PC is always a multiple of 4.
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

  // next_pc is both the ROM address this cycle and the f2_pc value after
  // the edge, so the PC register and the ROM read can never disagree.
  always_comb begin
    state_nxt    = state;
    f2_valid_nxt = f2_valid;
    next_pc      = f2_pc;
`ifdef FETCH_MISALIGN_EN
    f2_misalign_nxt = f2_misalign;
`endif
    case (state)
      IDLE: begin
        next_pc      = redirect_valid ? redirect_tgt : RESET_PC;
        state_nxt    = RUN;
        f2_valid_nxt = 1'b1;
`ifdef FETCH_MISALIGN_EN
        f2_misalign_nxt = redirect_valid & (redirect_pc[1:0] != 2'b00);
`endif
      end
      RUN: begin
        if (redirect_valid) begin
          // Kill the instruction on rom_data and fetch the target.
          next_pc      = redirect_tgt;
          f2_valid_nxt = 1'b1;
`ifdef FETCH_MISALIGN_EN
          f2_misalign_nxt = (redirect_pc[1:0] != 2'b00);
`endif
        end else if (f2_valid && !out_ready) begin
          // Re-read the same word so rom_data stays stable across the stall.
          next_pc = f2_pc;
        end else begin
          next_pc = f2_pc + 32'd4;
`ifdef FETCH_MISALIGN_EN
          f2_misalign_nxt = 1'b0;
`endif
        end
      end
      default: begin
        state_nxt    = IDLE;
        f2_valid_nxt = 1'b0;
        next_pc      = RESET_PC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state    <= IDLE;
      f2_valid <= 1'b0;
      f2_pc    <= RESET_PC;
`ifdef FETCH_MISALIGN_EN
      f2_misalign <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      f2_valid <= f2_valid_nxt;
      f2_pc    <= next_pc;
`ifdef FETCH_MISALIGN_EN
      f2_misalign <= f2_misalign_nxt;
`endif
    end
  end

  // Indices beyond the ROM alias by truncation of the word address.
  assign rom_addr  = next_pc[DEPTH_LOG+1:2];

  // A redirect forces out_valid low the same cycle, so decode never
  // accepts the instruction being killed.
  assign out_valid = f2_valid & ~redirect_valid & (state == RUN);
  assign out_instr = rom_data;
  assign out_pc    = f2_pc;

`ifdef FETCH_MISALIGN_EN
  assign out_misalign = f2_misalign & out_valid;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch

module tb_instr_fetch;

  localparam int DEPTH_LOG = 12;

  logic                 clk;
  logic                 resetb;
  logic [DEPTH_LOG-1:0] rom_addr;
  logic [31:0]          rom_data;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic [31:0]          out_pc;
`ifdef FETCH_MISALIGN_EN
  logic                 out_misalign;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [0:(1<<DEPTH_LOG)-1];

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH_LOG(DEPTH_LOG),
    .WIDTH    (32)
  ) dut (
    .clk           (clk),
    .resetb        (resetb),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
`ifdef FETCH_MISALIGN_EN
    .out_misalign  (out_misalign),
`endif
    .out_pc        (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM model, 1-cycle read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct {
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        chk_instr;
    logic [31:0] e_instr;
    logic [31:0] e_addr;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rv, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] epc, input logic ci,
                     input logic [31:0] ei, input logic [31:0] ea, input logic em);
    vec_t v;
    v.ready = r; v.rv = rv; v.rpc = rpc; v.e_valid = ev; v.e_pc = epc;
    v.chk_instr = ci; v.e_instr = ei; v.e_addr = ea; v.e_mis = em;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [31:0] epc,
                            input logic ci, input logic [31:0] ei, input logic [31:0] ea);
    chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    chk({tag, " out_pc"}, out_pc, epc);
    if (ci) chk({tag, " out_instr"}, out_instr, ei);
    chk({tag, " rom_addr"}, {20'd0, rom_addr}, ea);
  endtask

  // Drive inputs just after a rising edge, leave them until the falling edge.
  task automatic step(input logic r, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    out_ready      = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  logic [31:0] pc_mis0, pc_mis1;

  initial begin
    for (int i = 0; i < (1 << DEPTH_LOG); i++) rom[i] = 32'h1000 + i;
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;

`ifdef FETCH_MISALIGN_EN
    pc_mis0 = 32'h42; pc_mis1 = 32'h46;
`else
    pc_mis0 = 32'h40; pc_mis1 = 32'h44;
`endif

    //   ready rv  rpc     valid pc      ci  instr     addr   mis
    add(1, 0, 32'h0,  0, 32'h0,   0, 32'h0,    32'h0,  0); // IDLE bubble
    add(1, 0, 32'h0,  1, 32'h0,   1, 32'h11,   32'h1,  0);
    add(1, 0, 32'h0,  1, 32'h4,   1, 32'h22,   32'h2,  0);
    add(0, 0, 32'h0,  1, 32'h8,   1, 32'h33,   32'h2,  0); // stall x3
    add(0, 0, 32'h0,  1, 32'h8,   1, 32'h33,   32'h2,  0);
    add(0, 0, 32'h0,  1, 32'h8,   1, 32'h33,   32'h2,  0);
    add(1, 0, 32'h0,  1, 32'h8,   1, 32'h33,   32'h3,  0);
    add(1, 0, 32'h0,  1, 32'hC,   1, 32'h44,   32'h4,  0);
    add(1, 1, 32'h40, 0, 32'h10,  1, 32'h1004, 32'h10, 0); // redirect
    add(1, 0, 32'h0,  1, 32'h40,  1, 32'h1010, 32'h11, 0);
    add(1, 0, 32'h0,  1, 32'h44,  1, 32'h1011, 32'h12, 0);
    add(0, 1, 32'h80, 0, 32'h48,  1, 32'h1012, 32'h20, 0); // redirect in stall
    add(1, 0, 32'h0,  1, 32'h80,  1, 32'h1020, 32'h21, 0);
    add(1, 1, 32'h42, 0, 32'h84,  1, 32'h1021, 32'h10, 0); // misaligned target
    add(1, 0, 32'h0,  1, pc_mis0, 1, 32'h1010, 32'h11, 1);
    add(1, 0, 32'h0,  1, pc_mis1, 1, 32'h1011, 32'h12, 0);

    resetb = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    @(posedge clk);
    #1;
    resetb = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      out_ready      = vecs[i].ready;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                 vecs[i].chk_instr, vecs[i].e_instr, vecs[i].e_addr);
`ifdef FETCH_MISALIGN_EN
      chk($sformatf("vec%0d out_misalign", i), {31'd0, out_misalign}, {31'd0, vecs[i].e_mis});
`endif
    end

    // Asynchronous reset in the middle of a cycle.
    #2;
    resetb = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetb = 1'b1;
    out_ready = 1'b1; redirect_valid = 1'b0;
    @(negedge clk);
    check_outs("restart bubble", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1, 0, 32'h0);  check_outs("restart pc0", 1'b1, 32'h0, 1'b1, 32'h11, 32'h1);
    step(1, 0, 32'h0);  check_outs("restart pc4", 1'b1, 32'h4, 1'b1, 32'h22, 32'h2);
    step(1, 1, 32'h40); check_outs("redir at pc8", 1'b0, 32'h8, 1'b1, 32'h33, 32'h10);
    step(1, 0, 32'h0);  check_outs("redir tgt", 1'b1, 32'h40, 1'b1, 32'h1010, 32'h11);
    step(1, 0, 32'h0);  check_outs("redir tgt+4", 1'b1, 32'h44, 1'b1, 32'h1011, 32'h12);

    // Stall at pc 8, then redirect during the stall.
    step(1, 1, 32'h8);  check_outs("redir to 8", 1'b0, 32'h48, 1'b0, 32'h0, 32'h2);
    step(0, 0, 32'h0);  check_outs("stall pc8", 1'b1, 32'h8, 1'b1, 32'h33, 32'h2);
    step(0, 1, 32'h80); check_outs("stall redir", 1'b0, 32'h8, 1'b1, 32'h33, 32'h20);
    step(1, 0, 32'h0);  check_outs("stall redir tgt", 1'b1, 32'h80, 1'b1, 32'h1020, 32'h21);
    step(1, 0, 32'h0);  check_outs("stall redir tgt+4", 1'b1, 32'h84, 1'b1, 32'h1021, 32'h22);

    // PC wrap and word-address aliasing at the top of the address space.
    step(1, 1, 32'hFFFF_FFFC); check_outs("wrap redir", 1'b0, 32'h88, 1'b0, 32'h0, 32'hFFF);
    step(1, 0, 32'h0);  check_outs("wrap top", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h1FFF, 32'h0);
    step(1, 0, 32'h0);  check_outs("wrap zero", 1'b1, 32'h0, 1'b1, 32'h11, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion before 20000");
    $fatal(1);
  end

endmodule
